// File: rtl/axil_pkg.sv
// axil_pkg: shared types and default parameter values for the AXI-lite
// write slave and its FIFOs.
//   resp_t : AXI write response encoding (OKAY / SLVERR)
//   AXIL_*_DEF : default values for the axil_wr_slave parameters
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  localparam int AXIL_ADDR_W_DEF     = 32;
  localparam int AXIL_DATA_W_DEF     = 32;
  localparam int AXIL_FIFO_DEPTH_DEF = 2;
  localparam int AXIL_REG_NUM_DEF    = 16;

endpackage

// File: rtl/axil_sync_fifo.sv
// axil_sync_fifo: single-clock FIFO with first-word fall-through output.
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push, din    : write request and data; ignored while full
//   pop, dout    : read request and head-of-queue data; ignored while empty
//   full, empty  : occupancy flags, derived only from registered state
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module axil_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/axil_wr_slave.sv
// axil_wr_slave: AXI4-lite write-only slave driving a simple register-file
// write port.
//   clk, rst                      : clock, synchronous active-high reset
//   s_axi_aw*  (addr/valid/ready) : write address channel, buffered in a FIFO
//   s_axi_w*   (data/strb/valid/ready) : write data channel, buffered in a FIFO
//   s_axi_b*   (resp/valid/ready) : write response, at most one outstanding
//   reg_wr_en/idx/data/strb       : one-cycle register write strobe
// Optional feature: define AXIL_WR_SLVERR_EN to answer unaligned or
// out-of-range addresses with SLVERR and suppress the register write.
// Without it every write is issued to the truncated index with OKAY.
module axil_wr_slave
  import axil_pkg::*;
#(
  parameter int ADDR_W     = AXIL_ADDR_W_DEF,
  parameter int DATA_W     = AXIL_DATA_W_DEF,
  parameter int FIFO_DEPTH = AXIL_FIFO_DEPTH_DEF,
  parameter int REG_NUM    = AXIL_REG_NUM_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          s_axi_awaddr,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [DATA_W-1:0]          s_axi_wdata,
  input  logic [DATA_W/8-1:0]        s_axi_wstrb,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  output logic                       reg_wr_en,
  output logic [$clog2(REG_NUM)-1:0] reg_wr_idx,
  output logic [DATA_W-1:0]          reg_wr_data,
  output logic [DATA_W/8-1:0]        reg_wr_strb
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(REG_NUM);
  localparam int OFF_W  = $clog2(STRB_W);

  logic              rdy_en_q, rdy_en_d;
  logic              aw_full, aw_empty, w_full, w_empty;
  logic [ADDR_W-1:0] aw_addr;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              pop;
  logic              addr_err;
  logic [IDX_W-1:0]  addr_idx;

  logic              bvalid_q, bvalid_d;
  resp_t             bresp_q, bresp_d;
  logic              wr_en_q, wr_en_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [STRB_W-1:0] wr_strb_q, wr_strb_d;

  // Readies stay low while in reset and for the reset cycle itself, then
  // follow the FIFO full flags; no input reaches them combinationally.
  assign s_axi_awready = rdy_en_q && !aw_full;
  assign s_axi_wready  = rdy_en_q && !w_full;

  axil_sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_aw_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_axi_awvalid && s_axi_awready),
    .din   (s_axi_awaddr),
    .pop   (pop),
    .dout  (aw_addr),
    .full  (aw_full),
    .empty (aw_empty)
  );

  axil_sync_fifo #(
    .WIDTH (DATA_W + STRB_W),
    .DEPTH (FIFO_DEPTH)
  ) u_w_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_axi_wvalid && s_axi_wready),
    .din   ({s_axi_wdata, s_axi_wstrb}),
    .pop   (pop),
    .dout  ({w_data, w_strb}),
    .full  (w_full),
    .empty (w_empty)
  );

  // A pair retires when both heads exist and the single B slot is free or
  // being freed this cycle, which keeps one write per cycle under bready.
  assign pop      = !aw_empty && !w_empty && (!bvalid_q || s_axi_bready);
  assign addr_idx = aw_addr[OFF_W +: IDX_W];

`ifdef AXIL_WR_SLVERR_EN
  localparam logic [ADDR_W-1:0] REG_NUM_C = ADDR_W'(REG_NUM);
  logic [ADDR_W-1:0] word_addr;

  // Any nonzero upper bit makes the word address reach REG_NUM or beyond.
  assign word_addr = aw_addr >> OFF_W;
  assign addr_err  = (aw_addr[OFF_W-1:0] != '0) || (word_addr >= REG_NUM_C);
`else
  logic unused_addr_bits;

  assign unused_addr_bits = ^{aw_addr[ADDR_W-1:OFF_W+IDX_W], aw_addr[OFF_W-1:0]};
  assign addr_err         = 1'b0;
`endif

  always_comb begin
    rdy_en_d  = 1'b1;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wr_en_d   = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    wr_strb_d = wr_strb_q;
    if (s_axi_bready) bvalid_d = 1'b0;
    if (pop) begin
      bvalid_d = 1'b1;
      bresp_d  = addr_err ? SLVERR : OKAY;
      if (!addr_err) begin
        wr_en_d   = 1'b1;
        wr_idx_d  = addr_idx;
        wr_data_d = w_data;
        wr_strb_d = w_strb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_en_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
    end else begin
      rdy_en_q  <= rdy_en_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
      wr_strb_q <= wr_strb_d;
    end
  end

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign reg_wr_en    = wr_en_q;
  assign reg_wr_idx   = wr_idx_q;
  assign reg_wr_data  = wr_data_q;
  assign reg_wr_strb  = wr_strb_q;

endmodule

// File: tb/tb_axil_wr_slave.sv
// tb_axil_wr_slave: self-checking bench for axil_wr_slave. A queue-based
// model predicts readies, the B channel and register writes every cycle;
// directed scenarios add literal expectations; a randomized phase follows.
`timescale 1ns/1ps
module tb_axil_wr_slave;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int REG_NUM    = 16;
  localparam int STRB_W     = DATA_W / 8;
  localparam int IDX_W      = $clog2(REG_NUM);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } w_beat_t;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] s_axi_awaddr = '0;
  logic              s_axi_awvalid = 1'b0;
  logic              s_axi_awready;
  logic [DATA_W-1:0] s_axi_wdata = '0;
  logic [STRB_W-1:0] s_axi_wstrb = '0;
  logic              s_axi_wvalid = 1'b0;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready = 1'b1;
  logic              reg_wr_en;
  logic [IDX_W-1:0]  reg_wr_idx;
  logic [DATA_W-1:0] reg_wr_data;
  logic [STRB_W-1:0] reg_wr_strb;

  always #5 clk = ~clk;

  axil_wr_slave #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .REG_NUM    (REG_NUM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .reg_wr_en     (reg_wr_en),
    .reg_wr_idx    (reg_wr_idx),
    .reg_wr_data   (reg_wr_data),
    .reg_wr_strb   (reg_wr_strb)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [ADDR_W-1:0] m_aw_q[$];
  w_beat_t           m_w_q[$];
  bit                m_started = 1'b0;
  bit                m_in_rst  = 1'b0;
  bit                m_rdy     = 1'b0;
  bit                m_bvalid  = 1'b0;
  bit                m_en      = 1'b0;
  logic [1:0]        m_bresp   = 2'b00;
  logic [IDX_W-1:0]  m_idx     = '0;
  logic [DATA_W-1:0] m_data    = '0;
  logic [STRB_W-1:0] m_strb    = '0;
  bit                e_awready = 1'b0;
  bit                e_wready  = 1'b0;
  logic [ADDR_W-1:0] m_a;
  w_beat_t           m_w;
  bit                m_pop, m_acc_aw, m_acc_w;

  function automatic bit addr_bad(input logic [ADDR_W-1:0] a);
`ifdef AXIL_WR_SLVERR_EN
    return ((a % 32'(STRB_W)) != 32'd0) || ((a / 32'(STRB_W)) >= 32'(REG_NUM));
`else
    return (a != a);
`endif
  endfunction

  always @(posedge clk) begin
    m_started = 1'b1;
    if (rst) begin
      m_aw_q.delete();
      m_w_q.delete();
      m_in_rst = 1'b1;
      m_rdy    = 1'b0;
      m_bvalid = 1'b0;
      m_bresp  = 2'b00;
      m_en     = 1'b0;
      m_idx    = '0;
      m_data   = '0;
      m_strb   = '0;
    end else begin
      m_acc_aw = s_axi_awvalid && e_awready;
      m_acc_w  = s_axi_wvalid && e_wready;
      m_pop    = (m_aw_q.size() > 0) && (m_w_q.size() > 0) && (!m_bvalid || s_axi_bready);
      m_in_rst = 1'b0;
      m_en     = 1'b0;
      if (s_axi_bready) m_bvalid = 1'b0;
      if (m_pop) begin
        m_a      = m_aw_q.pop_front();
        m_w      = m_w_q.pop_front();
        m_bvalid = 1'b1;
        if (addr_bad(m_a)) begin
          m_bresp = 2'b10;
        end else begin
          m_bresp = 2'b00;
          m_en    = 1'b1;
          m_idx   = IDX_W'((m_a / 32'(STRB_W)) % 32'(REG_NUM));
          m_data  = m_w.data;
          m_strb  = m_w.strb;
        end
      end
      if (m_acc_aw) m_aw_q.push_back(s_axi_awaddr);
      if (m_acc_w)  m_w_q.push_back('{data: s_axi_wdata, strb: s_axi_wstrb});
      m_rdy = 1'b1;
    end
    e_awready = m_rdy && (m_aw_q.size() < FIFO_DEPTH);
    e_wready  = m_rdy && (m_w_q.size() < FIFO_DEPTH);
  end

  // ---------------- per-cycle comparison ----------------
  wr_t        wr_log[$];
  logic [1:0] b_log[$];

  always @(negedge clk) begin
    if (m_started) begin
      check("awready", 64'(s_axi_awready), 64'(e_awready));
      check("wready", 64'(s_axi_wready), 64'(e_wready));
      check("bvalid", 64'(s_axi_bvalid), 64'(m_bvalid));
      check("reg_wr_en", 64'(reg_wr_en), 64'(m_en));
      if (m_bvalid || m_in_rst) check("bresp", 64'(s_axi_bresp), 64'(m_bresp));
      if (m_en || m_in_rst) begin
        check("reg_wr_idx", 64'(reg_wr_idx), 64'(m_idx));
        check("reg_wr_data", 64'(reg_wr_data), 64'(m_data));
        check("reg_wr_strb", 64'(reg_wr_strb), 64'(m_strb));
      end
      if (reg_wr_en) begin
        wr_log.push_back('{idx: reg_wr_idx, data: reg_wr_data, strb: reg_wr_strb});
        $display("%0t WRITE idx=%0d data=0x%08h strb=0x%0h", $time, reg_wr_idx, reg_wr_data, reg_wr_strb);
      end
      if (s_axi_bvalid && s_axi_bready) begin
        b_log.push_back(s_axi_bresp);
        $display("%0t BRESP resp=%0d", $time, s_axi_bresp);
      end
    end
  end

  // ---------------- drivers (called just after a rising edge) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [ADDR_W-1:0] a);
    bit hs;
    s_axi_awaddr  = a;
    s_axi_awvalid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      hs = s_axi_awready;
      tick();
      if (hs) break;
      if (n == 299) begin
        checks++;
        errors++;
        $display("FAIL aw_timeout: awready never seen for addr 0x%0h", a);
      end
    end
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    bit hs;
    s_axi_wdata  = d;
    s_axi_wstrb  = s;
    s_axi_wvalid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      hs = s_axi_wready;
      tick();
      if (hs) break;
      if (n == 299) begin
        checks++;
        errors++;
        $display("FAIL w_timeout: wready never seen for data 0x%0h", d);
      end
    end
    s_axi_wvalid = 1'b0;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    int unsigned r = $urandom_range(0, 9);
    logic [ADDR_W-1:0] a = 32'($urandom_range(0, REG_NUM - 1)) * 32'(STRB_W);
    if (r == 0)      a = a + 32'($urandom_range(1, STRB_W - 1));
    else if (r == 1) a = a + 32'($urandom_range(1, 255)) * 32'(STRB_W * REG_NUM);
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hs_aw, hs_w;

    // Reset and release.
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_awready", 64'(s_axi_awready), 64'd0);
    check("rst_wready", 64'(s_axi_wready), 64'd0);
    check("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("rst_reg_wr_en", 64'(reg_wr_en), 64'd0);
    check("rst_reg_wr_data", 64'(reg_wr_data), 64'd0);
    tick();
    @(negedge clk);
    check("post_rst_awready", 64'(s_axi_awready), 64'd1);
    check("post_rst_wready", 64'(s_axi_wready), 64'd1);
    tick();

    // Single write, both channels in the same cycle: visible two cycles later.
    s_axi_bready  = 1'b1;
    s_axi_awaddr  = 32'h8;
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = 32'hDEADBEEF;
    s_axi_wstrb   = 4'hF;
    s_axi_wvalid  = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    @(negedge clk);
    check("single_en_cycle1", 64'(reg_wr_en), 64'd0);
    tick();
    @(negedge clk);
    check("single_en_cycle2", 64'(reg_wr_en), 64'd1);
    check("single_idx", 64'(reg_wr_idx), 64'd2);
    check("single_data", 64'(reg_wr_data), 64'hDEADBEEF);
    check("single_strb", 64'(reg_wr_strb), 64'hF);
    check("single_bvalid", 64'(s_axi_bvalid), 64'd1);
    check("single_bresp", 64'(s_axi_bresp), 64'd0);
    tick();
    repeat (3) tick();

    // Three W beats ahead of their addresses.
    wr_log.delete();
    send_w(32'h1111_0000, 4'hF);
    send_w(32'h2222_0000, 4'h3);
    @(negedge clk);
    check("w_first_wready_low", 64'(s_axi_wready), 64'd0);
    tick();
    fork
      send_w(32'h3333_0000, 4'h0);
      begin
        send_aw(32'h0);
        send_aw(32'h4);
        send_aw(32'h8);
      end
    join
    repeat (5) tick();
    check("w_first_count", 64'(wr_log.size()), 64'd3);
    if (wr_log.size() == 3) begin
      check("w_first_idx0", 64'(wr_log[0].idx), 64'd0);
      check("w_first_data0", 64'(wr_log[0].data), 64'h1111_0000);
      check("w_first_idx1", 64'(wr_log[1].idx), 64'd1);
      check("w_first_data1", 64'(wr_log[1].data), 64'h2222_0000);
      check("w_first_idx2", 64'(wr_log[2].idx), 64'd2);
      check("w_first_strb2", 64'(wr_log[2].strb), 64'h0);
    end

    // B stall: held response, FIFOs fill, then drain in order.
    wr_log.delete();
    s_axi_bready = 1'b0;
    fork
      for (int i = 0; i < 4; i++) send_aw(32'h10 + 32'(i * 4));
      for (int i = 0; i < 4; i++) send_w(32'hA000_0000 + 32'(i), 4'hF);
      begin
        repeat (12) tick();
        @(negedge clk);
        check("stall_awready", 64'(s_axi_awready), 64'd0);
        check("stall_wready", 64'(s_axi_wready), 64'd0);
        check("stall_bvalid", 64'(s_axi_bvalid), 64'd1);
        check("stall_bresp", 64'(s_axi_bresp), 64'd0);
        check("stall_writes", 64'(wr_log.size()), 64'd1);
        tick();
        s_axi_bready = 1'b1;
      end
    join
    repeat (5) tick();
    check("stall_drain_count", 64'(wr_log.size()), 64'd4);
    if (wr_log.size() == 4) begin
      check("stall_drain_idx3", 64'(wr_log[3].idx), 64'd7);
      check("stall_drain_data3", 64'(wr_log[3].data), 64'hA000_0003);
    end

    // Out-of-range and unaligned addresses.
    wr_log.delete();
    b_log.delete();
    fork
      send_aw(32'h100);
      send_w(32'h5555_5555, 4'hF);
    join
    fork
      send_aw(32'h6);
      send_w(32'h6666_6666, 4'hC);
    join
    repeat (6) tick();
    check("odd_addr_bcount", 64'(b_log.size()), 64'd2);
`ifdef AXIL_WR_SLVERR_EN
    check("odd_addr_writes", 64'(wr_log.size()), 64'd0);
    if (b_log.size() == 2) begin
      check("odd_addr_resp0", 64'(b_log[0]), 64'd2);
      check("odd_addr_resp1", 64'(b_log[1]), 64'd2);
    end
`else
    check("odd_addr_writes", 64'(wr_log.size()), 64'd2);
    if (wr_log.size() == 2) begin
      check("odd_addr_idx0", 64'(wr_log[0].idx), 64'd0);
      check("odd_addr_idx1", 64'(wr_log[1].idx), 64'd1);
    end
    if (b_log.size() == 2) check("odd_addr_resp1", 64'(b_log[1]), 64'd0);
`endif

    // Reset with two buffered pairs and one pending response.
    s_axi_bready = 1'b0;
    fork
      for (int i = 0; i < 3; i++) send_aw(32'h20 + 32'(i * 4));
      for (int i = 0; i < 3; i++) send_w(32'hB000_0000 + 32'(i), 4'hF);
    join
    @(negedge clk);
    check("prerst_bvalid", 64'(s_axi_bvalid), 64'd1);
    tick();
    wr_log.delete();
    b_log.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_axi_bready = 1'b1;
    @(negedge clk);
    check("midrst_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("midrst_awready", 64'(s_axi_awready), 64'd0);
    tick();
    @(negedge clk);
    check("midrst_rdy_back", 64'(s_axi_awready & s_axi_wready), 64'd1);
    repeat (6) tick();
    check("midrst_no_writes", 64'(wr_log.size()), 64'd0);
    check("midrst_no_bresp", 64'(b_log.size()), 64'd0);

    // Randomized traffic, one mid-run reset and a full-throughput stretch.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      hs_aw = s_axi_awvalid && s_axi_awready;
      hs_w  = s_axi_wvalid && s_axi_wready;
      tick();
      rst = (cyc == 900);
      if (cyc >= 1200 && cyc < 1300) begin
        if (!s_axi_awvalid || hs_aw) begin
          s_axi_awvalid = 1'b1;
          s_axi_awaddr  = rand_addr();
        end
        if (!s_axi_wvalid || hs_w) begin
          s_axi_wvalid = 1'b1;
          s_axi_wdata  = $urandom;
          s_axi_wstrb  = STRB_W'($urandom);
        end
        s_axi_bready = 1'b1;
      end else if (rst) begin
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
      end else begin
        if (!s_axi_awvalid || hs_aw) begin
          s_axi_awvalid = ($urandom_range(0, 99) < 55);
          s_axi_awaddr  = rand_addr();
        end
        if (!s_axi_wvalid || hs_w) begin
          s_axi_wvalid = ($urandom_range(0, 99) < 55);
          s_axi_wdata  = $urandom;
          s_axi_wstrb  = STRB_W'($urandom);
        end
        s_axi_bready = ($urandom_range(0, 99) < 70);
      end
    end
    rst           = 1'b0;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_wr_slave.md
AXIL_WR_SLAVE -- requirements
Module: axil_wr_slave

Interface
REQ-001 Parameter ADDR_W, default 32: AXI-lite write address width.
REQ-002 Parameter DATA_W, default 32: write data width; legal values are 32 or 64; strobe width is DATA_W/8.
REQ-003 Parameter FIFO_DEPTH, default 2: per-channel AW and W buffer depth; power of two, >=2.
REQ-004 Parameter REG_NUM, default 16: number of DATA_W/8-byte registers decoded from address 0; IDX_W = clog2(REG_NUM).
REQ-005 clk  in  1  single clock; all logic rises on posedge clk.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 s_axi_awaddr  in  ADDR_W  write address; s_axi_awvalid  in  1; s_axi_awready  out  1.
REQ-008 s_axi_wdata  in  DATA_W; s_axi_wstrb  in  DATA_W/8; s_axi_wvalid  in  1; s_axi_wready  out  1.
REQ-009 s_axi_bresp  out  2; s_axi_bvalid  out  1; s_axi_bready  in  1.
REQ-010 reg_wr_en  out  1  one-cycle register write pulse; reg_wr_idx  out  IDX_W  register index; reg_wr_data  out  DATA_W; reg_wr_strb  out  DATA_W/8.

Function
REQ-011 AW and W channels shall be accepted independently, each into its own FIFO; a beat is accepted on the cycle where valid and ready are both high.
REQ-012 s_axi_awready shall be !aw_full and s_axi_wready shall be !w_full, both registered-state derived, with no combinational path from any input.
REQ-013 A full FIFO shall hold ready low even in a cycle where it pops.
REQ-014 A pair shall pop when both FIFOs are non-empty and the B slot is free (!s_axi_bvalid || s_axi_bready).
REQ-015 Pops shall pair AW and W entries in strict arrival order per channel.
REQ-016 In the cycle after a pop, reg_wr_en shall be 1 for exactly one cycle, with reg_wr_idx = awaddr[IDX_W+log2(DATA_W/8)-1 : log2(DATA_W/8)], plus reg_wr_data and reg_wr_strb from the W entry.
REQ-017 s_axi_bvalid shall rise in the same cycle as the corresponding reg_wr_en.
REQ-018 Minimum latency from AW and W handshakes in cycle 0 to reg_wr_en/bvalid is 2 cycles.
REQ-019 s_axi_bvalid and s_axi_bresp shall remain stable until the cycle s_axi_bready is high; the slot frees in that cycle, and a back-to-back pop is allowed in that same cycle.
REQ-020 wstrb = 0 shall still produce a reg_wr_en pulse with reg_wr_strb = 0 and a response of OKAY.
REQ-021 FIFO pointers shall wrap modulo FIFO_DEPTH; a simultaneous push and pop on a non-full, non-empty FIFO shall leave its occupancy unchanged.
REQ-022 At most one write response shall be outstanding at any time; throughput is one write per cycle while s_axi_bready is held high.

Reset
REQ-023 When rst is high at a clock edge, both FIFOs shall empty and any pending B response shall be discarded.
REQ-024 Reset values: s_axi_awready=0, s_axi_wready=0, s_axi_bvalid=0, s_axi_bresp=0, reg_wr_en=0, reg_wr_idx=0, reg_wr_data=0, reg_wr_strb=0.
REQ-025 The ready outputs shall go high in the first cycle after rst deasserts.
REQ-026 Reset asserted mid-transaction shall produce no reg_wr_en pulse for any buffered beat.

Configuration
REQ-027 With AXIL_WR_SLVERR_EN defined, an address that is unaligned or has index >= REG_NUM (upper bits nonzero included) shall give bresp=SLVERR (2'b10) with reg_wr_en held 0; bvalid timing is unchanged.
REQ-028 Without AXIL_WR_SLVERR_EN, every write shall give bresp=OKAY (2'b00) and the address shall be truncated to its index bits, so the write is always issued.

Structure
REQ-029 Package axil_pkg shall hold the resp_t enum (OKAY=2'b00, SLVERR=2'b10) and the default parameter constants.
REQ-030 Sub-module axil_sync_fifo (generic width/depth, full/empty flags) shall be instantiated twice, once for AW and once for W.

Verification
REQ-031 Single write, AW and W in the same cycle to 0x8, data 0xDEADBEEF, strb 0xF -> reg_wr_en 2 cycles later, idx=2, data=0xDEADBEEF, bresp=OKAY.
REQ-032 Three W beats before any AW, then three AWs 0x0/0x4/0x8 -> writes in order to idx 0/1/2 with matching data; wready low after the 2nd W beat.
REQ-033 bready held low for 10 cycles, with further AW/W beats arriving -> bvalid/bresp stable, no extra reg_wr_en, both readies drop when the FIFOs fill.
REQ-034 Write to 0x100 with REG_NUM=16, and a write to 0x6 -> SLVERR, no reg_wr_en (macro defined); OKAY with idx 0 and idx 1 (macro undefined).
REQ-035 rst pulsed high with 2 buffered pairs and one pending B -> bvalid=0 next cycle, no reg_wr_en afterwards, readies high one cycle after rst drops.
